// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - IF stage bus bundle (hazard unit, ROM and IF/ID signals)
//
// Purpose: groups every non-clock/reset signal of the fetch stage.
// Ports (signals):
//   StallF, StallD, FlushD    hazard-unit controls into IF
//   PCSrcE, PCTargetE         EX-stage redirect request and byte target
//   A, RD                     instruction ROM word address / combinational read data
//   PCF                       current fetch PC
//   InstrD, PCD, PCPlus4D     IF/ID pipeline register contents
//   ValidD                    IF/ID holds a real instruction (0 = bubble)
//   MisalignErr               sticky misaligned-redirect flag
// Modports: slave = fetch unit, master = surrounding core / testbench.
interface instruction_fetch_unit_if #(
  parameter int AW    = 8,
  parameter int WIDTH = 32
);
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             PCSrcE;
  logic [31:0]      PCTargetE;
  logic [AW-1:0]    A;
  logic [WIDTH-1:0] RD;
  logic [31:0]      PCF;
  logic [WIDTH-1:0] InstrD;
  logic [31:0]      PCD;
  logic [31:0]      PCPlus4D;
  logic             ValidD;
  logic             MisalignErr;

  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, RD,
    output A, PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignErr
  );

  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, RD,
    input  A, PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignErr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I IF stage: PC register, next-PC select, IF/ID register
//
// Purpose: owns the fetch PC, addresses the combinational instruction ROM and
// registers the fetched word, its PC and PC+4 for decode.
// Ports:
//   clk    core clock, rising-edge state updates
//   reset  asynchronous active-high reset
//   bus    instruction_fetch_unit_if.slave (hazard controls, redirect, ROM, IF/ID outputs)
module instruction_fetch_unit #(
  parameter int          DEPTH    = 256,
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.slave  bus
);
  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [WIDTH-1:0] NOP    = WIDTH'(32'h0000_0013);

  logic [31:0]      pcf_q,       pcf_d;
  logic [WIDTH-1:0] instr_q,     instr_d;
  logic [31:0]      pcd_q,       pcd_d;
  logic [31:0]      pc_plus4d_q, pc_plus4d_d;
  logic             valid_q,     valid_d;
  logic             misalign_q,  misalign_d;
  logic [31:0]      pc_plus4_f;

  always_comb begin
    pc_plus4_f  = pcf_q + 32'd4;  // wraps silently at 2^32
    pcf_d       = pc_plus4_f;
    instr_d     = bus.RD;
    pcd_d       = pcf_q;
    pc_plus4d_d = pc_plus4_f;
    valid_d     = 1'b1;
    misalign_d  = misalign_q;

    // Redirect beats StallF: a resolved branch must never be lost to a stall.
    if (bus.PCSrcE) begin
      pcf_d = {bus.PCTargetE[31:2], 2'b00};
      if (bus.PCTargetE[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (bus.StallF) begin
      pcf_d = pcf_q;
    end

    // A redirect squashes the wrong-path word currently on RD, even under StallD.
    if (bus.FlushD || bus.PCSrcE) begin
      instr_d     = NOP;
      pcd_d       = 32'd0;
      pc_plus4d_d = 32'd0;
      valid_d     = 1'b0;
    end else if (bus.StallD) begin
      instr_d     = instr_q;
      pcd_d       = pcd_q;
      pc_plus4d_d = pc_plus4d_q;
      valid_d     = valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q       <= RESET_PC_AL;
      instr_q     <= NOP;
      pcd_q       <= 32'd0;
      pc_plus4d_q <= 32'd0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pcf_q       <= pcf_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pc_plus4d_q <= pc_plus4d_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
    end
  end

  // ROM is word addressed; upper PC bits alias modulo DEPTH.
  assign bus.A           = pcf_q[AW+1:2];
  assign bus.PCF         = pcf_q;
  assign bus.InstrD      = instr_q;
  assign bus.PCD         = pcd_q;
  assign bus.PCPlus4D    = pc_plus4d_q;
  assign bus.ValidD      = valid_q;
  assign bus.MisalignErr = misalign_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] rom [256];

  instruction_fetch_unit_if #(.AW(8), .WIDTH(32)) bus0 ();
  instruction_fetch_unit_if #(.AW(8), .WIDTH(32)) bus1 ();

  assign bus0.RD = rom[bus0.A];
  assign bus1.RD = rom[bus1.A];

  instruction_fetch_unit #(.DEPTH(256), .WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  instruction_fetch_unit #(.DEPTH(256), .WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus0.StallF = 0; bus0.StallD = 0; bus0.FlushD = 0; bus0.PCSrcE = 0; bus0.PCTargetE = 0;
    bus1.StallF = 0; bus1.StallD = 0; bus1.FlushD = 0; bus1.PCSrcE = 0; bus1.PCTargetE = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus0.StallF = 0; bus0.StallD = 0; bus0.FlushD = 0; bus0.PCSrcE = 0; bus0.PCTargetE = 0;
    bus1.StallF = 0; bus1.StallD = 0; bus1.FlushD = 0; bus1.PCSrcE = 0; bus1.PCTargetE = 0;
    reset = 1'b1;
    #1;
    checks++; if (bus0.PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h expected %h", bus0.PCF, 32'h0); end
    checks++; if (bus0.InstrD !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus0.InstrD, 32'h13); end
    checks++; if (bus0.PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h expected %h", bus0.PCD, 32'h0); end
    checks++; if (bus0.PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcplus4d: got %h expected %h", bus0.PCPlus4D, 32'h0); end
    checks++; if (bus0.ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus0.ValidD); end
    checks++; if (bus0.MisalignErr !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", bus0.MisalignErr); end
    checks++; if (bus0.A !== 8'h00) begin errors++; $display("FAIL reset_a: got %h expected 00", bus0.A); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset();
    step();
    checks++; if (bus0.PCF !== 32'h4) begin errors++; $display("FAIL run1_pcf: got %h expected %h", bus0.PCF, 32'h4); end
    checks++; if (bus0.InstrD !== 32'h00500113) begin errors++; $display("FAIL run1_instr: got %h expected %h", bus0.InstrD, 32'h00500113); end
    checks++; if (bus0.PCD !== 32'h0) begin errors++; $display("FAIL run1_pcd: got %h expected %h", bus0.PCD, 32'h0); end
    checks++; if (bus0.PCPlus4D !== 32'h4) begin errors++; $display("FAIL run1_pcplus4d: got %h expected %h", bus0.PCPlus4D, 32'h4); end
    checks++; if (bus0.ValidD !== 1'b1) begin errors++; $display("FAIL run1_valid: got %b expected 1", bus0.ValidD); end
    step();
    checks++; if (bus0.InstrD !== 32'h00c00193) begin errors++; $display("FAIL run2_instr: got %h expected %h", bus0.InstrD, 32'h00c00193); end
    step();
    checks++; if (bus0.PCF !== 32'hC) begin errors++; $display("FAIL run3_pcf: got %h expected %h", bus0.PCF, 32'hC); end
    checks++; if (bus0.InstrD !== 32'hff718393) begin errors++; $display("FAIL run3_instr: got %h expected %h", bus0.InstrD, 32'hff718393); end
    checks++; if (bus0.PCD !== 32'h8) begin errors++; $display("FAIL run3_pcd: got %h expected %h", bus0.PCD, 32'h8); end
    checks++; if (bus0.A !== 8'h03) begin errors++; $display("FAIL run3_a: got %h expected 03", bus0.A); end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    bus0.StallF = 1; bus0.StallD = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus0.PCF !== 32'h8) begin errors++; $display("FAIL stall_pcf[%0d]: got %h expected %h", i, bus0.PCF, 32'h8); end
      checks++; if (bus0.InstrD !== 32'h00c00193) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, bus0.InstrD, 32'h00c00193); end
      checks++; if (bus0.PCD !== 32'h4) begin errors++; $display("FAIL stall_pcd[%0d]: got %h expected %h", i, bus0.PCD, 32'h4); end
    end
    bus0.StallF = 0; bus0.StallD = 0;
    step();
    checks++; if (bus0.InstrD !== 32'hff718393) begin errors++; $display("FAIL unstall_instr: got %h expected %h", bus0.InstrD, 32'hff718393); end
    checks++; if (bus0.PCD !== 32'h8) begin errors++; $display("FAIL unstall_pcd: got %h expected %h", bus0.PCD, 32'h8); end
    checks++; if (bus0.PCF !== 32'hC) begin errors++; $display("FAIL unstall_pcf: got %h expected %h", bus0.PCF, 32'hC); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 7; i++) step();
    checks++; if (bus0.PCF !== 32'h1C) begin errors++; $display("FAIL redir_pre_pcf: got %h expected %h", bus0.PCF, 32'h1C); end
    bus0.PCSrcE = 1; bus0.PCTargetE = 32'h28;
    step();
    bus0.PCSrcE = 0; bus0.PCTargetE = 32'h0;
    checks++; if (bus0.PCF !== 32'h28) begin errors++; $display("FAIL redir_pcf: got %h expected %h", bus0.PCF, 32'h28); end
    checks++; if (bus0.InstrD !== 32'h13) begin errors++; $display("FAIL redir_bubble_instr: got %h expected %h", bus0.InstrD, 32'h13); end
    checks++; if (bus0.ValidD !== 1'b0) begin errors++; $display("FAIL redir_bubble_valid: got %b expected 0", bus0.ValidD); end
    checks++; if (bus0.MisalignErr !== 1'b0) begin errors++; $display("FAIL redir_aligned_err: got %b expected 0", bus0.MisalignErr); end
    step();
    checks++; if (bus0.InstrD !== 32'h0023a233) begin errors++; $display("FAIL redir_instr: got %h expected %h", bus0.InstrD, 32'h0023a233); end
    checks++; if (bus0.PCD !== 32'h28) begin errors++; $display("FAIL redir_pcd: got %h expected %h", bus0.PCD, 32'h28); end
    checks++; if (bus0.PCPlus4D !== 32'h2C) begin errors++; $display("FAIL redir_pcplus4d: got %h expected %h", bus0.PCPlus4D, 32'h2C); end
    checks++; if (bus0.ValidD !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b expected 1", bus0.ValidD); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    step();
    step();
    bus0.StallD = 1; bus0.FlushD = 1;
    step();
    checks++; if (bus0.ValidD !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b expected 0", bus0.ValidD); end
    checks++; if (bus0.InstrD !== 32'h13) begin errors++; $display("FAIL flush_stall_instr: got %h expected %h", bus0.InstrD, 32'h13); end
    checks++; if (bus0.PCD !== 32'h0) begin errors++; $display("FAIL flush_stall_pcd: got %h expected %h", bus0.PCD, 32'h0); end
    checks++; if (bus0.PCF !== 32'hC) begin errors++; $display("FAIL flush_stall_pcf: got %h expected %h", bus0.PCF, 32'hC); end
    bus0.StallD = 0; bus0.FlushD = 0; bus0.StallF = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus0.PCF !== 32'hC) begin errors++; $display("FAIL stallf_pcf[%0d]: got %h expected %h", i, bus0.PCF, 32'hC); end
      checks++; if (bus0.InstrD !== 32'h0023e233) begin errors++; $display("FAIL stallf_instr[%0d]: got %h expected %h", i, bus0.InstrD, 32'h0023e233); end
      checks++; if (bus0.PCD !== 32'hC) begin errors++; $display("FAIL stallf_pcd[%0d]: got %h expected %h", i, bus0.PCD, 32'hC); end
    end
    bus0.StallF = 1; bus0.StallD = 1; bus0.PCSrcE = 1; bus0.PCTargetE = 32'h40;
    step();
    bus0.StallF = 0; bus0.StallD = 0; bus0.PCSrcE = 0; bus0.PCTargetE = 32'h0;
    checks++; if (bus0.PCF !== 32'h40) begin errors++; $display("FAIL redir_over_stall_pcf: got %h expected %h", bus0.PCF, 32'h40); end
    checks++; if (bus0.ValidD !== 1'b0) begin errors++; $display("FAIL redir_over_stall_valid: got %b expected 0", bus0.ValidD); end
  endtask

  task automatic test_misalign();
    do_reset();
    step();
    bus0.PCSrcE = 1; bus0.PCTargetE = 32'h2A;
    step();
    bus0.PCSrcE = 0; bus0.PCTargetE = 32'h0;
    checks++; if (bus0.PCF !== 32'h28) begin errors++; $display("FAIL misalign_pcf: got %h expected %h", bus0.PCF, 32'h28); end
    checks++; if (bus0.MisalignErr !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b expected 1", bus0.MisalignErr); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus0.MisalignErr !== 1'b1) begin errors++; $display("FAIL misalign_sticky[%0d]: got %b expected 1", i, bus0.MisalignErr); end
    end
    reset = 1'b1;
    #1;
    checks++; if (bus0.MisalignErr !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", bus0.MisalignErr); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_pc_wrap();
    reset = 1'b1;
    #1;
    checks++; if (bus1.PCF !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_reset_pcf: got %h expected %h", bus1.PCF, 32'hFFFFFFFC); end
    checks++; if (bus1.A !== 8'hFF) begin errors++; $display("FAIL wrap_reset_a: got %h expected ff", bus1.A); end
    do_reset();
    step();
    checks++; if (bus1.PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf: got %h expected %h", bus1.PCF, 32'h0); end
    checks++; if (bus1.PCD !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pcd: got %h expected %h", bus1.PCD, 32'hFFFFFFFC); end
    checks++; if (bus1.PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4d: got %h expected %h", bus1.PCPlus4D, 32'h0); end
    checks++; if (bus1.ValidD !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", bus1.ValidD); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 12; i++) step();
    checks++; if (bus0.PCF !== 32'h30) begin errors++; $display("FAIL async_pre_pcf: got %h expected %h", bus0.PCF, 32'h30); end
    bus0.StallF = 1; bus0.StallD = 1;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus0.PCF !== 32'h0) begin errors++; $display("FAIL async_pcf: got %h expected %h", bus0.PCF, 32'h0); end
    checks++; if (bus0.ValidD !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", bus0.ValidD); end
    checks++; if (bus0.InstrD !== 32'h13) begin errors++; $display("FAIL async_instr: got %h expected %h", bus0.InstrD, 32'h13); end
    bus0.StallF = 0; bus0.StallD = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0]  = 32'h00500113; rom[1]  = 32'h00c00193; rom[2]  = 32'hff718393;
    rom[3]  = 32'h0023e233; rom[4]  = 32'h0041f2b3; rom[5]  = 32'h004282b3;
    rom[6]  = 32'h02728863; rom[7]  = 32'h0041a233; rom[8]  = 32'h00020463;
    rom[9]  = 32'h00000293; rom[10] = 32'h0023a233; rom[11] = 32'h005203b3;
    rom[12] = 32'h402383b3; rom[13] = 32'h0471aa23; rom[14] = 32'h06002103;
    rom[15] = 32'h005104b3; rom[16] = 32'h008001ef; rom[17] = 32'h00100113;
    rom[18] = 32'h00910133; rom[19] = 32'h0221a023; rom[20] = 32'h00210063;

    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_flush_priority();
    test_misalign();
    test_reset_pc_wrap();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage of the pipelined RV32I core, directly upstream of the combinational instruction ROM (word-addressed, depth 256 × 32).
- Owns the program counter and drives the ROM word address.
- Selects next-PC among sequential, stall-hold and branch/jump redirect.
- Registers the fetched word, PC and PC+4 into the IF/ID pipeline register consumed by decode.
- Accepts stall/flush from the hazard unit.

Parameters:
DEPTH, 256, instruction ROM depth in words; AW = $clog2(DEPTH)
WIDTH, 32, instruction width in bits
RESET_PC, 32'h00000000, PC value loaded on reset

Ports:
clk  input  1  single core clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
StallF  input  1  hold PC this cycle
StallD  input  1  hold IF/ID register this cycle
FlushD  input  1  replace IF/ID contents with bubble
PCSrcE  input  1  taken branch/jump resolved in EX; redirect PC
PCTargetE  input  32  redirect target byte address
A  output  AW  ROM word address = PCF[AW+1:2]
RD  input  WIDTH  ROM read data for A (combinational)
PCF  output  32  current fetch PC
InstrD  output  WIDTH  registered instruction to decode
PCD  output  32  registered PC of InstrD
PCPlus4D  output  32  registered PCD+4
ValidD  output  1  InstrD is a real fetched instruction (0 = bubble)
MisalignErr  output  1  sticky: redirect target had nonzero bits [1:0]

Behaviour:
- Reset (async, immediate, also mid-operation): PCF=RESET_PC with bits[1:0] forced 0; InstrD=32'h00000013 (NOP); PCD=0; PCPlus4D=0; ValidD=0; MisalignErr=0. First rising edge after reset deassertion is a normal fetch cycle.
- A is purely combinational from PCF: A = PCF[AW+1:2]. PCs beyond DEPTH*4 alias modulo DEPTH words; no error.
- PCPlus4F = PCF + 4, modulo 2^32. Wrap from 0xFFFFFFFC to 0 is legal and silent.
- PC update per edge, priority order:
  1. PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}. Overrides StallF.
  2. StallF=1: PCF holds.
  3. Otherwise: PCF <= PCPlus4F.
- Misaligned target: PCSrcE=1 with PCTargetE[1:0]≠0 sets MisalignErr=1. The flag stays set until reset; the PC still loads the truncated target.
- IF/ID update per edge, priority order:
  1. FlushD=1 or PCSrcE=1: bubble (InstrD=NOP 0x00000013, PCD=0, PCPlus4D=0, ValidD=0). The wrong-path instruction is squashed internally; the hazard unit need not assert FlushD for redirects.
  2. StallD=1: all IF/ID outputs hold.
  3. Otherwise: InstrD<=RD, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Latency: the instruction at PCF=P appears on InstrD/PCD one edge later. Redirect penalty is one bubble in D, plus whatever EX-side flush the hazard unit applies.
- Simultaneous events:
  - StallD=1 with FlushD=1: flush wins.
  - StallF=1 with StallD=0: D still captures the (repeated) RD; the hazard unit is responsible for consistent use.
  - PCSrcE=1 with StallD=1: flush wins, bubble inserted.
- No combinational path from any input to PCF, InstrD, PCD, PCPlus4D, ValidD or MisalignErr. A depends only on PCF.

Test Plan:
- Reset then free-run with the standard 21-word test program in ROM → PCF = 0, 4, 8…; cycle 1: InstrD=00500113, PCD=0, PCPlus4D=4, ValidD=1; cycle 3: InstrD=ff718393, PCD=8.
- StallF=StallD=1 for 2 cycles while PCF=0x08 → PCF stays 0x08, InstrD stays 00c00193 (PCD=4); after release, InstrD=ff718393, PCD=8.
- PCSrcE=1, PCTargetE=0x28 while PCF=0x1C → next edge PCF=0x28, InstrD=NOP, ValidD=0; following edge InstrD=0023a233, PCD=0x28, PCPlus4D=0x2C.
- PCSrcE=1, PCTargetE=0x2A → PCF=0x28, MisalignErr=1, which stays 1 through 10 further cycles until reset.
- RESET_PC=32'hFFFFFFFC → after reset, A=0xFF; first edge PCF=0, PCPlus4D=0, PCD=0xFFFFFFFC.
- Assert reset asynchronously mid-cycle during a stall with PCF=0x30 → PCF=0, ValidD=0, InstrD=NOP immediately, without waiting for a clock edge.
